out_display: RTL and testbench
==============================

// Module: out_display
// PURPOSE
//  Display driver downstream of the output register. Consumes the 8-bit OBUS value and
//  converts it to 3 decimal digits with a sequential shift-add-3 (double-dabble) FSM.
//  Drives a multiplexed 3-digit 7-segment display through one shared segment bus.
//  Sits between the output register and the board display pins. No other block reads it.
// PARAMETERS
//  SCAN_DIV        1024  CLK cycles per digit scan slot (>=1)
//  BLANK_LZ        1     1 = blank leading zeros in hundreds/tens; 0 = show all 3 digits
//  SEG_ACTIVE_LOW  0     1 = invert SEG outputs (common-anode panel)
// PORTS
//  CLK   in   1  system clock; all state updates on posedge
//  CLR   in   1  reset, asynchronous, active-high
//  OBUS  in   8  unsigned value from the output register (changes on CLK negedge)
//  SEG   out  7  segments {g,f,e,d,c,b,a}, bit0 = a
//  DIG   out  3  one-hot digit enable: 001 = ones, 010 = tens, 100 = hundreds
//  BUSY  out  1  conversion in progress
// BEHAVIOUR
//  Registers: last (8), bin (8), bcd (12), cnt (3), state, disp (12), pre, idx (2).
//  Reset (CLR=1, async): state=IDLE, last=0, bin=0, bcd=0, cnt=0, disp=0, pre=0, idx=0.
//   Outputs during and after reset: BUSY=0, DIG=001, SEG=7'h3F (digit 0; inverted if active-low).
//  FSM states:
//   IDLE:  if OBUS!=last -> bin<=OBUS, last<=OBUS, bcd<=0, cnt<=0, goto SHIFT. Else stay.
//   SHIFT: for each BCD nibble >=5 add 3, then shift {bcd,bin} left by 1; cnt++.
//          When cnt==7 on this edge, goto LATCH (exactly 8 SHIFT edges).
//   LATCH: disp<=bcd, goto IDLE.
//  BUSY=1 in SHIFT and LATCH. Capture at edge k -> disp updated at edge k+9.
//  OBUS is ignored outside IDLE. If OBUS changes mid-conversion, the old value finishes.
//   The new value then differs from last and is captured on the first IDLE edge (k+10).
//  OBUS equal to last never starts a conversion. After reset, OBUS=0 needs no conversion.
//  Scan: pre counts 0..SCAN_DIV-1. On wrap, pre<=0 and idx advances 0->1->2->0.
//   SCAN_DIV=1 advances every edge. idx is 2 bits; value 3 never occurs.
//  DIG = one-hot of idx (registered state only, no glitching).
//  SEG = decode of disp nibble selected by idx.
//   0-9 -> 3F,06,5B,4F,66,6D,7D,07,7F,6F. Nibble >9 cannot occur.
//  Blanking (BLANK_LZ=1):
//   hundreds blank if 0; tens blank if hundreds==0 && tens==0; ones never blank.
//   Blank = SEG 7'h00 before inversion. DIG stays asserted.
//  SEG_ACTIVE_LOW=1: SEG output is the bitwise inverse; DIG polarity unchanged.
//  Scan runs independently of conversion. The display shows old disp until LATCH.
//  CLR mid-conversion: aborts immediately, all state returns to reset values.
//   After release, a nonzero OBUS is captured on the first posedge.
// TESTING
//  1 Reset, SCAN_DIV=4, OBUS=0
//    -> BUSY=0, DIG=001, SEG=3F.
//    -> After 4 edges DIG=010, SEG=00; after 8 edges DIG=100, SEG=00; after 12 edges DIG=001.
//  2 OBUS=255 captured at edge k
//    -> BUSY=1 edges k..k+8, 0 after k+9.
//    -> Scan then shows ones 6D, tens 6D, hundreds 5B.
//  3 Blanking: OBUS=7 -> ones 07, tens 00, hundreds 00.
//    OBUS=105 -> ones 6D, tens 3F (not blanked), hundreds 06.
//    BLANK_LZ=0 with OBUS=7 -> tens 3F, hundreds 3F.
//  4 OBUS=200 at edge k, changed to 42 before edge k+3
//    -> disp=200 after k+9; 42 captured at k+10; disp=42 after k+19.
//  5 OBUS=99, CLR pulsed at edge k+4 mid-conversion
//    -> BUSY=0, SEG=3F, DIG=001 asynchronously.
//    -> After release, capture on first edge; disp=99 nine edges later.
//  6 SEG_ACTIVE_LOW=1, OBUS=8 -> ones SEG=00; blanked digits SEG=7F.

Source files
------------

// File: rtl/out_display.sv
`default_nettype none
// ============================================================================
//  Module   : out_display
//  Purpose  : Converts the 8-bit OBUS value to three BCD digits with a
//             sequential shift-add-3 converter. Drives a multiplexed 3-digit
//             7-segment display over one shared segment bus.
//  Revision : 1.0  initial release
// ============================================================================
module out_display #(
    parameter int SCAN_DIV       = 1024,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [7:0] OBUS,
    output logic [6:0] SEG,
    output logic [2:0] DIG,
    output logic       BUSY
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  last, last_nx;
    logic [7:0]  bin, bin_nx;
    logic [11:0] bcd, bcd_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [11:0] disp, disp_nx;
    logic [11:0] bcd_adj;

    logic [PRE_W-1:0] pre;
    logic [1:0]       idx;

    // Adjust one BCD nibble ahead of a shift so that it carries correctly.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Conversion state and datapath registers.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
            last  <= '0;
            bin   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            disp  <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            bin   <= bin_nx;
            bcd   <= bcd_nx;
            cnt   <= cnt_nx;
            disp  <= disp_nx;
        end
    end

    // Next-state and datapath logic: capture, eight shift steps, then latch.
    always_comb begin
        state_nx = state;
        last_nx  = last;
        bin_nx   = bin;
        bcd_nx   = bcd;
        cnt_nx   = cnt;
        disp_nx  = disp;
        bcd_adj  = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
        case (state)
            IDLE: begin
                if (OBUS != last) begin
                    bin_nx   = OBUS;
                    last_nx  = OBUS;
                    bcd_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_nx, bin_nx} = {bcd_adj[10:0], bin, 1'b0};
                cnt_nx           = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_nx = LATCH;
                end
            end
            LATCH: begin
                disp_nx  = bcd;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Digit scan: prescaler wraps every SCAN_DIV cycles and steps the digit index.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_MAX) begin
            pre <= '0;
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    logic [3:0] nib;
    logic       blank;
    logic [6:0] seg_raw;

    // Select the scanned digit, apply leading-zero blanking, decode segments.
    always_comb begin
        nib     = disp[3:0];
        blank   = 1'b0;
        seg_raw = 7'h00;
        DIG     = 3'b001;
        case (idx)
            2'd1: begin
                nib   = disp[7:4];
                blank = BLANK_LZ && (disp[11:8] == 4'd0) && (disp[7:4] == 4'd0);
                DIG   = 3'b010;
            end
            2'd2: begin
                nib   = disp[11:8];
                blank = BLANK_LZ && (disp[11:8] == 4'd0);
                DIG   = 3'b100;
            end
            default: begin
                nib = disp[3:0];
                DIG = 3'b001;
            end
        endcase
        case (nib)
            4'd0:    seg_raw = 7'h3F;
            4'd1:    seg_raw = 7'h06;
            4'd2:    seg_raw = 7'h5B;
            4'd3:    seg_raw = 7'h4F;
            4'd4:    seg_raw = 7'h66;
            4'd5:    seg_raw = 7'h6D;
            4'd6:    seg_raw = 7'h7D;
            4'd7:    seg_raw = 7'h07;
            4'd8:    seg_raw = 7'h7F;
            4'd9:    seg_raw = 7'h6F;
            default: seg_raw = 7'h00;
        endcase
        if (blank) begin
            seg_raw = 7'h00;
        end
        SEG = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    end

    assign BUSY = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_out_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_out_display
//  Purpose  : Self-checking bench for out_display. Three instances (default,
//             no blanking, active-low segments) share clock, reset and OBUS;
//             each is compared every cycle against a value-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_out_display;

    localparam int SD = 4;

    logic       CLK;
    logic       CLR;
    logic [7:0] obus;
    logic [6:0] seg_a, seg_b, seg_c;
    logic [2:0] dig_a, dig_b, dig_c;
    logic       busy_a, busy_b, busy_c;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: value awaiting display, cycles until it lands, edges since reset.
    int m_last, m_pend, m_disp, m_left, m_edges;

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    out_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_a (
        .CLK(CLK), .CLR(CLR), .OBUS(obus), .SEG(seg_a), .DIG(dig_a), .BUSY(busy_a));
    out_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_b (
        .CLK(CLK), .CLR(CLR), .OBUS(obus), .SEG(seg_b), .DIG(dig_b), .BUSY(busy_b));
    out_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_c (
        .CLK(CLK), .CLR(CLR), .OBUS(obus), .SEG(seg_c), .DIG(dig_c), .BUSY(busy_c));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_seg(input int v, input int idx, input bit blz, input bit al);
        int h, t, o, d;
        bit blank;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        d = (idx == 0) ? o : (idx == 1) ? t : h;
        blank = blz && ((idx == 2 && h == 0) || (idx == 1 && h == 0 && t == 0));
        return al ? int'(~(blank ? 7'h00 : seg_tab[d]) & 7'h7F) : int'(blank ? 7'h00 : seg_tab[d]);
    endfunction

    task automatic model_reset();
        m_last  = 0;
        m_pend  = 0;
        m_disp  = 0;
        m_left  = 0;
        m_edges = 0;
    endtask

    // One rising edge: a new OBUS value is accepted only when nothing is pending;
    // it reaches the display nine edges after capture.
    task automatic model_edge();
        m_edges++;
        if (m_left == 0) begin
            if (int'(obus) != m_last) begin
                m_last = obus;
                m_pend = obus;
                m_left = 9;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_disp = m_pend;
        end
    endtask

    task automatic check_all();
        int idx;
        int busy;
        idx  = (m_edges / SD) % 3;
        busy = (m_left > 0) ? 1 : 0;
        check("busy_a", busy_a, busy);
        check("busy_b", busy_b, busy);
        check("busy_c", busy_c, busy);
        check("dig_a", dig_a, 1 << idx);
        check("dig_b", dig_b, 1 << idx);
        check("dig_c", dig_c, 1 << idx);
        check("seg_a", seg_a, exp_seg(m_disp, idx, 1'b1, 1'b0));
        check("seg_b", seg_b, exp_seg(m_disp, idx, 1'b0, 1'b0));
        check("seg_c", seg_c, exp_seg(m_disp, idx, 1'b1, 1'b1));
    endtask

    // Entered and left at a falling edge; drives OBUS, then one rising edge.
    task automatic tick(input logic [7:0] v);
        obus = v;
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
        @(negedge CLK);
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    // Asynchronous reset pulse spanning one rising edge; ends at a falling edge.
    task automatic pulse_clr();
        #2;
        CLR = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    logic [7:0] corners [0:7] = '{8'd0, 8'd1, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd255};

    initial begin
        CLR  = 1'b1;
        obus = 8'd0;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        CLR = 1'b0;

        // Idle scan with zero value, then directed values including blanking cases.
        hold(8'd0, 13);
        hold(8'd255, 20);
        hold(8'd7, 20);
        hold(8'd105, 20);
        hold(8'd8, 20);
        // Value changes mid-conversion; old value finishes first.
        hold(8'd200, 2);
        hold(8'd42, 25);
        // Reset mid-conversion, then capture on first edge after release.
        hold(8'd99, 4);
        pulse_clr();
        hold(8'd99, 15);

        // Randomized values and hold times, with occasional reset pulses.
        for (int i = 0; i < 250; i++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)]
                                            : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) pulse_clr();
            hold(v, $urandom_range(1, 24));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
